// File: rtl/cov_bin_collector_if.sv
// Bus bundle between the monitored-bus driver (master) and the coverage
// collector (slave). Carries the sampled bus fields, clear, readback index
// and all coverage results.
interface cov_bin_collector_if #(
  parameter int CMD_W  = 2,
  parameter int ADR_W  = 3,
  parameter int DATA_W = 8
);
  logic [CMD_W-1:0]       cmd;
  logic [ADR_W-1:0]       adr;
  logic [DATA_W-1:0]      data;
  logic                   clr;
  logic [CMD_W+ADR_W-1:0] rd_idx;
  logic [7:0]             rd_cnt;
  logic [CMD_W+ADR_W:0]   uniq_cnt;
  logic [15:0]            total_cnt;
  logic                   new_bin;
  logic                   done;
  logic [DATA_W-1:0]      sig;

  modport master (
    output cmd, adr, data, clr, rd_idx,
    input  rd_cnt, uniq_cnt, total_cnt, new_bin, done, sig
  );

  modport slave (
    input  cmd, adr, data, clr, rd_idx,
    output rd_cnt, uniq_cnt, total_cnt, new_bin, done, sig
  );
endinterface

// File: rtl/cov_bin_collector.sv
// Functional-coverage bin collector. Every non-idle bus cycle is a sample
// landing in bin {cmd, adr}; tracks distinct bins hit, total samples
// (saturating), an XOR signature of sampled data and a sticky goal flag.
// Optional macro COV_HIT_CNT_EN adds per-bin 8-bit saturating hit counters
// with a registered, read-before-write readout on rd_cnt; without it rd_cnt
// is tied to 0.
module cov_bin_collector #(
  parameter int CMD_W  = 2,
  parameter int ADR_W  = 3,
  parameter int DATA_W = 8,
  parameter int GOAL   = 8
) (
  input logic clk,
  input logic rst,
  cov_bin_collector_if.slave bus
);
  localparam int IDX_W = CMD_W + ADR_W;
  localparam int NBINS = 1 << IDX_W;
  localparam logic [IDX_W:0] GOAL_V = (IDX_W+1)'(GOAL);

  logic              sample, is_new, wipe;
  logic [IDX_W-1:0]  idx;
  logic [NBINS-1:0]  bitmap_q, bitmap_d;
  logic [IDX_W:0]    uniq_q, uniq_d;
  logic [15:0]       total_q, total_d;
  logic [DATA_W-1:0] sig_q, sig_d;
  logic              new_bin_q, new_bin_d;
  logic              done_q, done_d;

  // clr and rst both wipe everything and override a coincident sample
  assign wipe = rst | bus.clr;

  // Sample decode and next-state for the shared coverage state
  always_comb begin
    sample    = (bus.cmd != '0);
    idx       = {bus.cmd, bus.adr};
    is_new    = sample && !bitmap_q[idx];
    bitmap_d  = bitmap_q;
    uniq_d    = uniq_q;
    total_d   = total_q;
    sig_d     = sig_q;
    new_bin_d = is_new;
    if (sample) begin
      bitmap_d[idx] = 1'b1;
      total_d       = (total_q == 16'hFFFF) ? total_q : total_q + 16'd1;
      sig_d         = sig_q ^ bus.data;
    end
    if (is_new) uniq_d = uniq_q + 1'b1;
    done_d = done_q | (uniq_d >= GOAL_V);
  end

  // Coverage state registers
  always_ff @(posedge clk) begin
    if (wipe) begin
      bitmap_q  <= '0;
      uniq_q    <= '0;
      total_q   <= '0;
      sig_q     <= '0;
      new_bin_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      bitmap_q  <= bitmap_d;
      uniq_q    <= uniq_d;
      total_q   <= total_d;
      sig_q     <= sig_d;
      new_bin_q <= new_bin_d;
      done_q    <= done_d;
    end
  end

`ifdef COV_HIT_CNT_EN
  logic [7:0] cnt_q [NBINS];
  logic [7:0] rd_cnt_q;

  // Per-bin saturating counters; readout captures the pre-update value
  always_ff @(posedge clk) begin
    if (wipe) begin
      for (int i = 0; i < NBINS; i++) cnt_q[i] <= 8'd0;
      rd_cnt_q <= 8'd0;
    end else begin
      rd_cnt_q <= cnt_q[bus.rd_idx];
      if (sample && cnt_q[idx] != 8'hFF) cnt_q[idx] <= cnt_q[idx] + 8'd1;
    end
  end

  assign bus.rd_cnt = rd_cnt_q;
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^bus.rd_idx;
  assign bus.rd_cnt    = 8'd0;
`endif

  assign bus.uniq_cnt  = uniq_q;
  assign bus.total_cnt = total_q;
  assign bus.new_bin   = new_bin_q;
  assign bus.done      = done_q;
  assign bus.sig       = sig_q;
endmodule

// File: tb/tb_cov_bin_collector.sv
// Self-checking bench for cov_bin_collector: directed scenarios followed by
// a randomized run, all compared against a set/count reference model.
module tb_cov_bin_collector;
  localparam int CMD_W = 2, ADR_W = 3, DATA_W = 8, GOAL = 8;
  localparam int NB = 1 << (CMD_W + ADR_W);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  cov_bin_collector_if #(.CMD_W(CMD_W), .ADR_W(ADR_W), .DATA_W(DATA_W)) bus ();

  cov_bin_collector #(.CMD_W(CMD_W), .ADR_W(ADR_W), .DATA_W(DATA_W), .GOAL(GOAL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: set of hit bins, per-bin hit tallies, sample count, signature
  bit        m_hit [NB];
  int        m_cnt [NB];
  int        m_total;
  bit [7:0]  m_sig;
  bit        m_new;
  int        m_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_uniq();
    int n = 0;
    for (int i = 0; i < NB; i++) n += m_hit[i] ? 1 : 0;
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NB; i++) begin
      m_hit[i] = 1'b0;
      m_cnt[i] = 0;
    end
    m_total = 0;
    m_sig   = '0;
    m_new   = 1'b0;
  endtask

  // One clock: drive, let the edge happen, advance model, compare all outputs
  task automatic cyc(input logic [1:0] c, input logic [2:0] a, input logic [7:0] d,
                     input logic cl, input logic rs, input logic [4:0] ri);
    int b;
    bus.cmd = c; bus.adr = a; bus.data = d; bus.clr = cl; bus.rd_idx = ri; rst = rs;
    @(posedge clk);
`ifdef COV_HIT_CNT_EN
    m_rd = (m_cnt[ri] > 255) ? 255 : m_cnt[ri];
`else
    m_rd = 0;
`endif
    if (rs || cl) begin
      model_clear();
      m_rd = 0;
    end else if (c != 0) begin
      b = {c, a};
      m_new = !m_hit[b];
      m_hit[b] = 1'b1;
      m_cnt[b]++;
      m_total++;
      m_sig ^= d;
    end else begin
      m_new = 1'b0;
    end
    #1;
    chk("uniq_cnt",  bus.uniq_cnt,  m_uniq());
    chk("total_cnt", bus.total_cnt, (m_total > 65535) ? 65535 : m_total);
    chk("sig",       bus.sig,       m_sig);
    chk("new_bin",   bus.new_bin,   m_new);
    chk("done",      bus.done,      (m_uniq() >= GOAL) ? 1 : 0);
    chk("rd_cnt",    bus.rd_cnt,    m_rd);
  endtask

  initial begin
    model_clear();
    bus.cmd = '0; bus.adr = '0; bus.data = '0; bus.clr = 1'b0; bus.rd_idx = '0;

    // Reset, then idle traffic must leave everything at zero
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(0, 3'(i), 8'hA5, 0, 0, 5'(i));
    chk("idle_uniq", bus.uniq_cnt, 0);

    // Two distinct bins: two pulses, signature 5^6
    cyc(2, 3, 5, 0, 0, 5'b10011);
    cyc(2, 4, 6, 0, 0, 5'b10011);
    cyc(0, 0, 0, 0, 0, 5'b10011);
    chk("two_uniq",  bus.uniq_cnt,  2);
    chk("two_total", bus.total_cnt, 2);
    chk("two_sig",   bus.sig,       3);

    // Hammer one bin 300 times; per-bin count saturates at 255
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 300; i++) cyc(2, 3, 8'($urandom), 0, 0, 5'b10011);
    cyc(0, 0, 0, 0, 0, 5'b10011);
    cyc(0, 0, 0, 0, 0, 5'b10011);
    chk("sat_uniq",  bus.uniq_cnt,  1);
    chk("sat_total", bus.total_cnt, 300);
`ifdef COV_HIT_CNT_EN
    chk("sat_rd_cnt", bus.rd_cnt, 255);
`else
    chk("sat_rd_cnt", bus.rd_cnt, 0);
`endif

    // Goal: 8 distinct bins raise done on the 8th sample, then it sticks
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 3'(i), 8'($urandom), 0, 0, 5'(i + 8));
      chk("done_edge", bus.done, (i == 7) ? 1 : 0);
    end
    for (int i = 0; i < 20; i++) begin
      cyc(2'($urandom_range(1, 3)), 3'($urandom), 8'($urandom), 0, 0, 5'($urandom));
      chk("done_hold", bus.done, 1);
    end

    // clr coinciding with a new-bin sample wins
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(3, 3'(i), 8'(i), 0, 0, 0);
    chk("pre_clr_uniq", bus.uniq_cnt, 5);
    cyc(3, 7, 8'h77, 1, 0, 0);
    chk("clr_uniq",    bus.uniq_cnt, 0);
    chk("clr_new_bin", bus.new_bin,  0);
    chk("clr_done",    bus.done,     0);

    // Mid-stream reset with cmd held: sample on the reset edge is lost
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'h11, 0, 0, 5'b01000);
    cyc(1, 0, 8'h11, 0, 1, 5'b01000);
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'h11, 0, 0, 5'b01000);
    chk("rst_total", bus.total_cnt, 4);
    chk("rst_sig",   bus.sig,       0);

    // Randomized traffic with occasional clr/rst
    for (int i = 0; i < 600; i++)
      cyc(2'($urandom), 3'($urandom), 8'($urandom),
          ($urandom_range(0, 31) == 0), ($urandom_range(0, 63) == 0), 5'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
